controle_multiciclo: RTL and testbench



---
 rtl/mips_pkg.sv | 90 +++++++++
 rtl/ctrl_decod_opcode.sv | 43 ++++
 rtl/controle_multiciclo.sv | 237 +++++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multi-cycle control path: opcodes, funct
// codes, ALUOp codes, controller states and datapath select encodings.
// The S_JR state exists only when CTRL_JR_EN is defined.
package mips_pkg;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct codes (instruction bits [5:0])
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  // ALUOp codes consumed by ula_ctrl
  localparam logic [3:0] ALUOP_RTYPE = 4'b0000;
  localparam logic [3:0] ALUOP_ADDI  = 4'b0001;
  localparam logic [3:0] ALUOP_ANDI  = 4'b0010;
  localparam logic [3:0] ALUOP_ORI   = 4'b0011;
  localparam logic [3:0] ALUOP_XORI  = 4'b0100;
  localparam logic [3:0] ALUOP_BEQ   = 4'b0101;
  localparam logic [3:0] ALUOP_BNE   = 4'b0110;
  localparam logic [3:0] ALUOP_SLTI  = 4'b0111;
  localparam logic [3:0] ALUOP_SLTIU = 4'b1000;
  localparam logic [3:0] ALUOP_LUI   = 4'b1001;
  localparam logic [3:0] ALUOP_LW    = 4'b1010;
  localparam logic [3:0] ALUOP_SW    = 4'b1011;

  // Register-file destination select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Write-back data select
  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // Instruction classes produced by the opcode decoder
  localparam logic [2:0] CLS_R       = 3'd0;
  localparam logic [2:0] CLS_MEM     = 3'd1;
  localparam logic [2:0] CLS_BRANCH  = 3'd2;
  localparam logic [2:0] CLS_JUMP    = 3'd3;
  localparam logic [2:0] CLS_IMM     = 3'd4;
  localparam logic [2:0] CLS_ILLEGAL = 3'd5;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
`ifdef CTRL_JR_EN
    ,
    S_JR        = 4'd12
`endif
  } state_e;

endpackage

// File: rtl/ctrl_decod_opcode.sv
// Combinational opcode decoder: instruction class, ALUOp code, immediate
// zero-extension flag and a legal flag for every supported opcode.
module ctrl_decod_opcode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic [2:0] cls_o,
  output logic [3:0] alu_op_o,
  output logic       ext_zero_o,
  output logic       legal_o
);

  // Opcode lookup; anything not listed is flagged illegal
  always_comb begin
    cls_o      = CLS_ILLEGAL;
    alu_op_o   = ALUOP_RTYPE;
    ext_zero_o = 1'b0;
    legal_o    = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin cls_o = CLS_R;      alu_op_o = ALUOP_RTYPE; legal_o = 1'b1; end
      OP_J:     begin cls_o = CLS_JUMP;   legal_o = 1'b1; end
      OP_JAL:   begin cls_o = CLS_JUMP;   legal_o = 1'b1; end
      OP_BEQ:   begin cls_o = CLS_BRANCH; alu_op_o = ALUOP_BEQ;   legal_o = 1'b1; end
      OP_BNE:   begin cls_o = CLS_BRANCH; alu_op_o = ALUOP_BNE;   legal_o = 1'b1; end
      OP_LW:    begin cls_o = CLS_MEM;    alu_op_o = ALUOP_LW;    legal_o = 1'b1; end
      OP_SW:    begin cls_o = CLS_MEM;    alu_op_o = ALUOP_SW;    legal_o = 1'b1; end
      OP_ADDI:  begin cls_o = CLS_IMM;    alu_op_o = ALUOP_ADDI;  legal_o = 1'b1; end
      OP_SLTI:  begin cls_o = CLS_IMM;    alu_op_o = ALUOP_SLTI;  legal_o = 1'b1; end
      OP_SLTIU: begin cls_o = CLS_IMM;    alu_op_o = ALUOP_SLTIU; legal_o = 1'b1; end
      OP_LUI:   begin cls_o = CLS_IMM;    alu_op_o = ALUOP_LUI;   legal_o = 1'b1; end
      OP_ANDI:  begin cls_o = CLS_IMM;    alu_op_o = ALUOP_ANDI;  ext_zero_o = 1'b1; legal_o = 1'b1; end
      OP_ORI:   begin cls_o = CLS_IMM;    alu_op_o = ALUOP_ORI;   ext_zero_o = 1'b1; legal_o = 1'b1; end
      OP_XORI:  begin cls_o = CLS_IMM;    alu_op_o = ALUOP_XORI;  ext_zero_o = 1'b1; legal_o = 1'b1; end
      default: begin
        cls_o      = CLS_ILLEGAL;
        alu_op_o   = ALUOP_RTYPE;
        ext_zero_o = 1'b0;
        legal_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch, decode, execute,
// memory and write-back, driving every datapath strobe and mux select.
// Optional macro CTRL_JR_EN: adds the JR state (opcode 0x00, funct 0x08).
// Opcode-derived information is captured in DECODE so later states never
// look at the instruction inputs again.
module controle_multiciclo
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_pronto,
  output logic [3:0] ALUOp,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtZero,
  output logic [1:0] PCSource,
  output logic       op_ilegal
);

  state_e     state_q, state_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic       ext_zero_q, ext_zero_d;
  logic       jal_q, jal_d;

  logic [2:0] dec_cls;
  logic [3:0] dec_alu_op;
  logic       dec_ext_zero;
  logic       dec_legal;

  // Ungated strobes; reset masking is applied at the ports
  logic pc_write, mem_read, mem_write, ir_write, reg_write, ilegal;

  ctrl_decod_opcode u_decod (
    .opcode_i   (opcode),
    .cls_o      (dec_cls),
    .alu_op_o   (dec_alu_op),
    .ext_zero_o (dec_ext_zero),
    .legal_o    (dec_legal)
  );

`ifndef CTRL_JR_EN
  // funct only matters for JR detection
  logic unused_funct;
  assign unused_funct = ^funct;
`endif

  // State and captured instruction info; reset returns to FETCH at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      alu_op_q   <= 4'b0000;
      ext_zero_q <= 1'b0;
      jal_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_op_q   <= alu_op_d;
      ext_zero_q <= ext_zero_d;
      jal_q      <= jal_d;
    end
  end

  // Capture decoder results during DECODE, hold them otherwise
  always_comb begin
    alu_op_d   = alu_op_q;
    ext_zero_d = ext_zero_q;
    jal_d      = jal_q;
    if (state_q == S_DECODE) begin
      alu_op_d   = dec_alu_op;
      ext_zero_d = dec_ext_zero;
      jal_d      = (opcode == OP_JAL);
    end else begin
      alu_op_d   = alu_op_q;
      ext_zero_d = ext_zero_q;
      jal_d      = jal_q;
    end
  end

  // Next-state sequencing, including memory-ready waits
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = mem_pronto ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!dec_legal) begin
          state_d = S_FETCH;
        end else begin
          case (dec_cls)
`ifdef CTRL_JR_EN
            CLS_R:      state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
`else
            CLS_R:      state_d = S_EXEC_R;
`endif
            CLS_MEM:    state_d = S_MEM_ADDR;
            CLS_BRANCH: state_d = S_BRANCH;
            CLS_JUMP:   state_d = S_JUMP;
            CLS_IMM:    state_d = S_EXEC_I;
            default:    state_d = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR:  state_d = (alu_op_q == ALUOP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_pronto ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_pronto ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_EXEC_I:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
`ifdef CTRL_JR_EN
      S_JR:        state_d = S_FETCH;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  // Moore output decode (plus mem_pronto in FETCH and zero in BRANCH)
  always_comb begin
    ALUOp     = ALUOP_RTYPE;
    pc_write  = 1'b0;
    IorD      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    RegDst    = REGDST_RT;
    MemtoReg  = MEMTOREG_ALUOUT;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REGB;
    ExtZero   = 1'b0;
    PCSource  = PCSRC_ALU;
    ilegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALUOP_LW;
        ir_write = mem_pronto;
        pc_write = mem_pronto;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BOFF;
        ALUOp   = ALUOP_LW;
        ilegal  = ~dec_legal;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = alu_op_q;
      end
      S_MEM_READ: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        RegDst    = REGDST_RT;
        MemtoReg  = MEMTOREG_MDR;
        reg_write = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REGB;
        ALUOp   = ALUOP_RTYPE;
      end
      S_R_WB: begin
        RegDst    = REGDST_RD;
        MemtoReg  = MEMTOREG_ALUOUT;
        reg_write = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = alu_op_q;
        ExtZero = ext_zero_q;
      end
      S_I_WB: begin
        RegDst    = REGDST_RT;
        MemtoReg  = MEMTOREG_ALUOUT;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_REGB;
        ALUOp    = alu_op_q;
        PCSource = PCSRC_ALUOUT;
        pc_write = (alu_op_q == ALUOP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        pc_write = 1'b1;
        if (jal_q) begin
          RegDst    = REGDST_RA;
          MemtoReg  = MEMTOREG_PC;
          reg_write = 1'b1;
        end else begin
          RegDst    = REGDST_RT;
          MemtoReg  = MEMTOREG_ALUOUT;
          reg_write = 1'b0;
        end
      end
`ifdef CTRL_JR_EN
      S_JR: begin
        PCSource = PCSRC_REGA;
        pc_write = 1'b1;
      end
`endif
      default: begin
        ALUOp = ALUOP_RTYPE;
      end
    endcase
  end

  // No write may escape while reset is held
  assign PCWrite   = pc_write  & rst_n;
  assign MemRead   = mem_read  & rst_n;
  assign MemWrite  = mem_write & rst_n;
  assign IRWrite   = ir_write  & rst_n;
  assign RegWrite  = reg_write & rst_n;
  assign op_ilegal = ilegal    & rst_n;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo. Each instruction is expanded
// by a reference model into a per-cycle list of expected control words,
// then played against the DUT while memory waits and zero are randomized.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_pronto;
  logic [3:0] ALUOp;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic       ALUSrcA, ExtZero, op_ilegal;

  always #5 clk = ~clk;

  controle_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_pronto(mem_pronto), .ALUOp(ALUOp), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtZero(ExtZero),
    .PCSource(PCSource), .op_ilegal(op_ilegal)
  );

  typedef struct packed {
    logic [3:0] aluop;
    logic       pcw, iord, mr, mw, irw, rw;
    logic [1:0] regdst, memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic       ext;
    logic [1:0] pcsrc;
    logic       ilg;
  } ctl_t;

  typedef struct {
    ctl_t  e;
    logic  mp;
    logic  z;
    string tag;
  } cyc_t;

  cyc_t plan[$];
  int   checks = 0;
  int   failures = 0;
  ctl_t obs;

  assign obs = {ALUOp, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtZero, PCSource, op_ilegal};

  function automatic ctl_t fetch_word(input logic done);
    ctl_t c = '0;
    c.aluop = 4'b1010; c.mr = 1'b1; c.srcb = 2'b01;
    c.irw = done; c.pcw = done;
    return c;
  endfunction

  function automatic ctl_t reset_word();
    ctl_t c = '0;
    c.aluop = 4'b1010; c.srcb = 2'b01;
    return c;
  endfunction

  task automatic check(input ctl_t e, input string tag);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic push(input ctl_t e, input logic mp, input logic z, input string tag);
    cyc_t c;
    c.e = e; c.mp = mp; c.z = z; c.tag = tag;
    plan.push_back(c);
  endtask

  // Reference model: expand one instruction into its expected cycle list
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm);
    ctl_t c;
    logic r;
    for (int i = 0; i < wf; i++) push(fetch_word(1'b0), 1'b0, z, "fetch_wait");
    push(fetch_word(1'b1), 1'b1, z, "fetch");
    c = '0; c.aluop = 4'b1010; c.srcb = 2'b11;
    r = 1'($urandom_range(0, 1));
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
      6'h0E, 6'h0F, 6'h23, 6'h2B: push(c, r, z, "decode");
      default: begin
        c.ilg = 1'b1;
        push(c, r, z, "decode_illegal");
        return;
      end
    endcase
    c = '0;
    if (op == 6'h00) begin
`ifdef CTRL_JR_EN
      if (fn == 6'h08) begin
        c.pcsrc = 2'b11; c.pcw = 1'b1;
        push(c, r, z, "jr");
        return;
      end
`endif
      c.srca = 1'b1; c.aluop = 4'b0000;
      push(c, r, z, "exec_r");
      c = '0; c.regdst = 2'b01; c.rw = 1'b1;
      push(c, r, z, "r_wb");
    end else if (op == 6'h23 || op == 6'h2B) begin
      c.srca = 1'b1; c.srcb = 2'b10; c.aluop = (op == 6'h23) ? 4'b1010 : 4'b1011;
      push(c, r, z, "mem_addr");
      c = '0; c.iord = 1'b1;
      if (op == 6'h23) c.mr = 1'b1; else c.mw = 1'b1;
      for (int i = 0; i < wm; i++) push(c, 1'b0, z, "mem_wait");
      push(c, 1'b1, z, "mem_access");
      if (op == 6'h23) begin
        c = '0; c.memtoreg = 2'b01; c.rw = 1'b1;
        push(c, r, z, "mem_wb");
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      c.srca = 1'b1; c.pcsrc = 2'b01;
      c.aluop = (op == 6'h04) ? 4'b0101 : 4'b0110;
      c.pcw = (op == 6'h04) ? z : ~z;
      push(c, r, z, "branch");
    end else if (op == 6'h02 || op == 6'h03) begin
      c.pcsrc = 2'b10; c.pcw = 1'b1;
      if (op == 6'h03) begin c.regdst = 2'b10; c.memtoreg = 2'b10; c.rw = 1'b1; end
      push(c, r, z, "jump");
    end else begin
      c.srca = 1'b1; c.srcb = 2'b10;
      case (op)
        6'h08: c.aluop = 4'b0001;
        6'h0C: begin c.aluop = 4'b0010; c.ext = 1'b1; end
        6'h0D: begin c.aluop = 4'b0011; c.ext = 1'b1; end
        6'h0E: begin c.aluop = 4'b0100; c.ext = 1'b1; end
        6'h0A: c.aluop = 4'b0111;
        6'h0B: c.aluop = 4'b1000;
        default: c.aluop = 4'b1001;
      endcase
      push(c, r, z, "exec_i");
      c = '0; c.rw = 1'b1;
      push(c, r, z, "i_wb");
    end
  endtask

  // Play up to n planned cycles (n < 0: all); entered just after a rising edge
  task automatic run_plan(input int n);
    int k = 0;
    cyc_t c;
    while (plan.size() > 0 && (n < 0 || k < n)) begin
      c = plan.pop_front();
      mem_pronto = c.mp;
      zero = c.z;
      @(negedge clk);
      check(c.e, c.tag);
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int wf, input int wm);
    opcode = op;
    funct = fn;
    build(op, fn, z, wf, wm);
    run_plan(-1);
  endtask

  logic [5:0] legal_ops [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                                 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

  initial begin
    logic [5:0] op, fn;
    rst_n = 1'b0; mem_pronto = 1'b1; zero = 1'b0;
    opcode = 6'h23; funct = 6'h20;

    // Reset held for three cycles with memory ready
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(reset_word(), "reset");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed instructions
    do_instr(6'h00, 6'h20, 1'b0, 0, 0);   // R-type add
    do_instr(6'h23, 6'h00, 1'b0, 0, 2);   // LW with two wait cycles
    do_instr(6'h2B, 6'h00, 1'b1, 1, 1);   // SW with waits
    do_instr(6'h04, 6'h00, 1'b1, 0, 0);   // BEQ taken
    do_instr(6'h04, 6'h00, 1'b0, 0, 0);   // BEQ not taken
    do_instr(6'h05, 6'h00, 1'b0, 0, 0);   // BNE taken
    do_instr(6'h05, 6'h00, 1'b1, 0, 0);   // BNE not taken
    do_instr(6'h0D, 6'h00, 1'b0, 0, 0);   // ORI
    do_instr(6'h03, 6'h00, 1'b0, 0, 0);   // JAL
    do_instr(6'h02, 6'h00, 1'b0, 2, 0);   // J after fetch wait
    do_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // illegal
    do_instr(6'h00, 6'h08, 1'b0, 0, 0);   // JR (R-type when JR disabled)
    do_instr(6'h0F, 6'h00, 1'b0, 0, 0);   // LUI

    // Reset asserted mid-LW while waiting on memory
    opcode = 6'h23; funct = 6'h00;
    build(6'h23, 6'h00, 1'b0, 0, 3);
    run_plan(4);
    plan.delete();
    rst_n = 1'b0;
    #1;
    check(reset_word(), "async_reset_mid");
    @(negedge clk);
    check(reset_word(), "reset_mid_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_instr(6'h00, 6'h20, 1'b0, 0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      else op = legal_ops[$urandom_range(0, 13)];
      fn = 6'($urandom_range(0, 63));
      if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'h08;
      do_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
